// File: rtl/traffic_timer.sv
// traffic_timer: prescaled interval timer for a traffic-light controller.
// A start request latches the shadow hold/yellow intervals into the active
// registers and restarts counting; each interval raises a sticky flag once
// the requested number of prescaled ticks has elapsed since that start.
module traffic_timer #(
  parameter int unsigned PRESCALE       = 1000,
  parameter logic [7:0]  HOLD_DEFAULT   = 8'd30,
  parameter logic [7:0]  YELLOW_DEFAULT = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       START_TIMER,
  input  logic       cfg_we,
  input  logic [7:0] cfg_hold,
  input  logic [7:0] cfg_yellow,
  output logic       T_HOLD,
  output logic       T_YELLOW,
  output logic       busy
);

  // Last prescaler value; a tick is issued in the cycle that holds it.
  localparam logic [15:0] LP_PS_LAST = 16'(PRESCALE - 1);

  // A zero interval would never expire, so it is promoted to one tick.
  function automatic logic [7:0] f_min_one(input logic [7:0] v);
    logic [7:0] res;
    if (v == 8'd0) begin
      res = 8'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [7:0]  r_sh_hold;
  logic [7:0]  r_sh_yellow;
  logic [7:0]  r_act_hold;
  logic [7:0]  r_act_yellow;
  logic [15:0] r_presc;
  logic [7:0]  r_tcnt;
  logic        r_t_hold;
  logic        r_t_yellow;

  logic        w_tick;
  logic        w_run;
  logic [15:0] w_presc_nxt;
  logic [7:0]  w_tcnt_nxt;
  logic        w_hold_hit;
  logic        w_yellow_hit;

  // Next-state terms for the prescaler, the saturating tick counter and expiry detection.
  always_comb begin
    w_tick       = 1'b0;
    w_run        = 1'b0;
    w_presc_nxt  = 16'd0;
    w_tcnt_nxt   = 8'd0;
    w_hold_hit   = 1'b0;
    w_yellow_hit = 1'b0;

    // Counting is frozen once both intervals have elapsed.
    if (r_t_hold && r_t_yellow) begin
      w_run = 1'b0;
    end else begin
      w_run = 1'b1;
    end

    if (r_presc == LP_PS_LAST) begin
      w_tick      = 1'b1;
      w_presc_nxt = 16'd0;
    end else begin
      w_tick      = 1'b0;
      w_presc_nxt = r_presc + 16'd1;
    end

    if (r_tcnt == 8'hFF) begin
      w_tcnt_nxt = r_tcnt;
    end else begin
      w_tcnt_nxt = r_tcnt + 8'd1;
    end

    // An interval expires on the tick edge where tcnt reaches its active value.
    if (w_tick && (w_tcnt_nxt == r_act_hold)) begin
      w_hold_hit = 1'b1;
    end else begin
      w_hold_hit = 1'b0;
    end

    if (w_tick && (w_tcnt_nxt == r_act_yellow)) begin
      w_yellow_hit = 1'b1;
    end else begin
      w_yellow_hit = 1'b0;
    end
  end

  // Shadow configuration registers, written by the configuration strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_hold   <= HOLD_DEFAULT;
      r_sh_yellow <= YELLOW_DEFAULT;
    end else if (cfg_we) begin
      r_sh_hold   <= cfg_hold;
      r_sh_yellow <= cfg_yellow;
    end else begin
      r_sh_hold   <= r_sh_hold;
      r_sh_yellow <= r_sh_yellow;
    end
  end

  // Active intervals: captured from the pre-write shadow values on every start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_hold   <= HOLD_DEFAULT;
      r_act_yellow <= YELLOW_DEFAULT;
    end else if (START_TIMER) begin
      r_act_hold   <= f_min_one(r_sh_hold);
      r_act_yellow <= f_min_one(r_sh_yellow);
    end else begin
      r_act_hold   <= r_act_hold;
      r_act_yellow <= r_act_yellow;
    end
  end

  // Prescaler, tick counter and sticky expiry flags; a start overrides any expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= 16'd0;
      r_tcnt     <= 8'd0;
      r_t_hold   <= 1'b1;
      r_t_yellow <= 1'b1;
    end else if (START_TIMER) begin
      r_presc    <= 16'd0;
      r_tcnt     <= 8'd0;
      r_t_hold   <= 1'b0;
      r_t_yellow <= 1'b0;
    end else if (w_run) begin
      r_presc <= w_presc_nxt;
      if (w_tick) begin
        r_tcnt <= w_tcnt_nxt;
      end else begin
        r_tcnt <= r_tcnt;
      end
      r_t_hold   <= r_t_hold | w_hold_hit;
      r_t_yellow <= r_t_yellow | w_yellow_hit;
    end else begin
      r_presc    <= r_presc;
      r_tcnt     <= r_tcnt;
      r_t_hold   <= r_t_hold;
      r_t_yellow <= r_t_yellow;
    end
  end

  assign T_HOLD   = r_t_hold;
  assign T_YELLOW = r_t_yellow;
  assign busy     = ~(r_t_hold & r_t_yellow);

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: three timers with different prescalers share one stimulus
// stream; a reference model tracks elapsed edges since the last start and
// predicts each flag as "edges elapsed >= interval * prescale".
module tb_traffic_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_hold = 8'd0;
  logic [7:0] cfg_yellow = 8'd0;
  logic [2:0] th;
  logic [2:0] ty;
  logic [2:0] bz;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_sh_h    = 30;
  int m_sh_y    = 5;
  int m_act_h   = 30;
  int m_act_y   = 5;
  bit m_started = 1'b0;
  int m_e       = 0;

  traffic_timer #(.PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .START_TIMER(start), .cfg_we(cfg_we),
    .cfg_hold(cfg_hold), .cfg_yellow(cfg_yellow),
    .T_HOLD(th[0]), .T_YELLOW(ty[0]), .busy(bz[0]));

  traffic_timer #(.PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .START_TIMER(start), .cfg_we(cfg_we),
    .cfg_hold(cfg_hold), .cfg_yellow(cfg_yellow),
    .T_HOLD(th[1]), .T_YELLOW(ty[1]), .busy(bz[1]));

  traffic_timer #(.PRESCALE(2)) u_p2 (
    .clk(clk), .reset(reset), .START_TIMER(start), .cfg_we(cfg_we),
    .cfg_hold(cfg_hold), .cfg_yellow(cfg_yellow),
    .T_HOLD(th[2]), .T_YELLOW(ty[2]), .busy(bz[2]));

  always #5 clk = ~clk;

  function automatic int ps_of(input int i);
    int p;
    case (i)
      0:       p = 4;
      1:       p = 1;
      default: p = 2;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh_h    = 30;
    m_sh_y    = 5;
    m_act_h   = 30;
    m_act_y   = 5;
    m_started = 1'b0;
    m_e       = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (start) begin
        m_act_h   = (m_sh_h == 0) ? 1 : m_sh_h;
        m_act_y   = (m_sh_y == 0) ? 1 : m_sh_y;
        m_started = 1'b1;
        m_e       = 0;
      end else if (m_started && m_e < 100000) begin
        m_e++;
      end
      if (cfg_we) begin
        m_sh_h = int'(cfg_hold);
        m_sh_y = int'(cfg_yellow);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int eh;
      int ey;
      eh = (!m_started || m_e >= m_act_h * ps_of(i)) ? 1 : 0;
      ey = (!m_started || m_e >= m_act_y * ps_of(i)) ? 1 : 0;
      chk($sformatf("t_hold_p%0d", ps_of(i)), int'(th[i]), eh);
      chk($sformatf("t_yellow_p%0d", ps_of(i)), int'(ty[i]), ey);
      chk($sformatf("busy_p%0d", ps_of(i)), int'(bz[i]), (eh == 1 && ey == 1) ? 0 : 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load_cfg(input int h, input int y);
    cfg_we     = 1'b1;
    cfg_hold   = 8'(h);
    cfg_yellow = 8'(y);
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic start_edge();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    model_reset();
    #2;
    chk("rst_thold", int'(th[0]), 1);
    chk("rst_tyellow", int'(ty[0]), 1);
    chk("rst_busy", int'(bz[0]), 0);
    step();
    step();
    reset = 1'b0;

    // Basic hold/yellow expiry with PRESCALE=4
    load_cfg(5, 2);
    start_edge();
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 7)  chk("b_y7", int'(ty[0]), 0);
      if (k == 8)  chk("b_y8", int'(ty[0]), 1);
      if (k == 19) chk("b_h19", int'(th[0]), 0);
      if (k == 20) begin
        chk("b_h20", int'(th[0]), 1);
        chk("b_busy20", int'(bz[0]), 0);
      end
    end

    // Restart in the middle of a running interval
    start_edge();
    for (int k = 1; k <= 35; k++) begin
      start = (k == 12);
      step();
      start = 1'b0;
      if (k == 12) chk("rs_y12", int'(ty[0]), 0);
      if (k == 20) begin
        chk("rs_y20", int'(ty[0]), 1);
        chk("rs_h20", int'(th[0]), 0);
      end
      if (k == 31) chk("rs_h31", int'(th[0]), 0);
      if (k == 32) chk("rs_h32", int'(th[0]), 1);
    end

    // Config write coinciding with start uses the old shadow value
    cfg_we     = 1'b1;
    cfg_hold   = 8'd3;
    cfg_yellow = 8'd2;
    start      = 1'b1;
    step();
    cfg_we = 1'b0;
    start  = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 19) chk("cw_h19", int'(th[0]), 0);
      if (k == 20) chk("cw_h20", int'(th[0]), 1);
    end
    start_edge();
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 11) chk("cw_h11", int'(th[0]), 0);
      if (k == 12) chk("cw_h12", int'(th[0]), 1);
    end

    // Zero intervals count as one tick
    load_cfg(0, 0);
    start_edge();
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        chk("z_h1_p1", int'(th[1]), 1);
        chk("z_y1_p1", int'(ty[1]), 1);
        chk("z_busy1_p1", int'(bz[1]), 0);
      end
      if (k == 4) chk("z_h4_p4", int'(th[0]), 1);
    end

    // Reset mid-interval aborts it; defaults apply afterwards
    load_cfg(5, 2);
    start_edge();
    for (int k = 1; k <= 10; k++) step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("ar_thold", int'(th[0]), 1);
    chk("ar_tyellow", int'(ty[0]), 1);
    chk("ar_busy", int'(bz[0]), 0);
    compare_all();
    #1 reset = 1'b0;
    for (int k = 1; k <= 60; k++) step();
    chk("ar_hold_stays", int'(th[0]), 1);
    start_edge();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) chk("def_y4_p1", int'(ty[1]), 0);
      if (k == 5) chk("def_y5_p1", int'(ty[1]), 1);
    end

    // Long interval reaching the tick counter ceiling
    load_cfg(255, 2);
    start_edge();
    for (int k = 1; k <= 600; k++) begin
      step();
      if (k == 509) chk("lh_h509_p2", int'(th[2]), 0);
      if (k == 510) chk("lh_h510_p2", int'(th[2]), 1);
      if (k == 600) chk("lh_h600_p2", int'(th[2]), 1);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (start && $urandom_range(0, 1) == 0) begin
        start = 1'b1;
      end else begin
        start = ($urandom_range(0, 39) == 0);
      end
      cfg_we     = ($urandom_range(0, 19) == 0);
      cfg_hold   = 8'($urandom_range(0, 12));
      cfg_yellow = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        #1 reset = 1'b0;
      end
      step();
    end
    start  = 1'b0;
    cfg_we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter PRESCALE, default 1000: clk cycles per timer tick; legal range 1..65535.
REQ-002 Parameter HOLD_DEFAULT, default 8'd30: hold interval, in ticks, loaded at reset.
REQ-003 Parameter YELLOW_DEFAULT, default 8'd5: yellow interval, in ticks, loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 START_TIMER  input  1  restart request from the light controller; sampled each rising edge.
REQ-007 cfg_we  input  1  write strobe for the shadow configuration registers.
REQ-008 cfg_hold  input  8  new hold interval in ticks.
REQ-009 cfg_yellow  input  8  new yellow interval in ticks.
REQ-010 T_HOLD  output  1  hold interval elapsed since the last start; registered level.
REQ-011 T_YELLOW  output  1  yellow interval elapsed since the last start; registered level.
REQ-012 busy  output  1  high while at least one of T_HOLD or T_YELLOW is still pending.

Function
REQ-013 The block SHALL hold shadow registers sh_hold and sh_yellow, each 8 bits; cfg_we high at an edge SHALL load both from cfg_hold and cfg_yellow.
REQ-014 The block SHALL hold active registers act_hold and act_yellow; START_TIMER high at an edge SHALL copy the shadow values into them.
REQ-015 When cfg_we and START_TIMER are both high at the same edge, act_* SHALL receive the pre-write shadow values, and the new values SHALL apply at the next start.
REQ-016 A zero shadow value SHALL be treated as 1 when copied to act_* (minimum interval 1 tick).
REQ-017 The prescaler SHALL be a 16-bit counter running 0..PRESCALE-1 that wraps to 0; a tick occurs in each cycle where the prescaler equals PRESCALE-1.
REQ-018 The tick counter tcnt SHALL be 8 bits, increment once per tick, and saturate at 255 with no wrap.
REQ-019 START_TIMER high at an edge SHALL clear the prescaler, tcnt, T_HOLD and T_YELLOW at that same edge, with no extra latency.
REQ-020 T_YELLOW SHALL go high at the edge where tcnt reaches act_yellow, which is exactly act_yellow*PRESCALE edges after the start edge.
REQ-021 T_HOLD SHALL go high exactly act_hold*PRESCALE edges after the start edge, by the same rule.
REQ-022 Once high, T_HOLD and T_YELLOW SHALL stay high until the next START_TIMER or reset.
REQ-023 A START_TIMER during a running interval SHALL restart both intervals from zero; no pending expiry from the earlier start SHALL appear.
REQ-024 START_TIMER held high for N cycles SHALL act as N consecutive restarts, so counting begins at the edge after the last high sample.
REQ-025 An expiry edge that coincides with START_TIMER SHALL be overridden: the outputs are cleared.
REQ-026 The order of expiry between yellow and hold SHALL be arbitrary; equal intervals SHALL assert both outputs at the same edge.
REQ-027 busy SHALL equal ~(T_HOLD & T_YELLOW) and be combinational from registered state.
REQ-028 Once both flags are set, the prescaler and tcnt MAY stop; restart behaviour SHALL be the same either way.

Reset
REQ-029 Reset SHALL asynchronously set sh_hold and act_hold to HOLD_DEFAULT, sh_yellow and act_yellow to YELLOW_DEFAULT, and the prescaler and tcnt to 0.
REQ-030 Reset SHALL set T_HOLD=1, T_YELLOW=1 and busy=0, so the controller sees elapsed timers and can leave its reset state as soon as it requests a start.
REQ-031 Reset asserted mid-interval SHALL abort the interval, and no expiry SHALL follow release.
REQ-032 The first edge after reset release SHALL be a normal functional edge.

Verification
REQ-033 PRESCALE=4, cfg hold=5 yellow=2, one-cycle START at edge 0 -> T_YELLOW high at edge 8, T_HOLD high at edge 20, busy low from edge 20.
REQ-034 Same setup, second START at edge 12 -> T_YELLOW low at edge 12, high again at edge 20; T_HOLD high at edge 32, not at edge 20.
REQ-035 cfg_we with hold=3 in the same cycle as START -> that interval uses the old hold=5 (expiry at edge 20); the next START uses 3 (expiry 12 edges later).
REQ-036 cfg yellow=0 hold=0, PRESCALE=1, START at edge 0 -> both outputs high at edge 1.
REQ-037 Reset pulsed at edge 10 of a running interval -> T_HOLD=T_YELLOW=1 immediately and act values at defaults; with no START afterwards there is no further toggle.
REQ-038 hold=255, PRESCALE=2, START, then run 600 cycles -> T_HOLD high at edge 510 and stays high; tcnt holds at 255 without wrapping.
